// File: rtl/nios_oci_trace_monitor.sv
// nios_oci_trace_monitor: multi-channel Nios II OCI DCT trace capture into one shared FWFT FIFO, with drain/done tracking.
// Ports: clk, reset_n (async active-low); dct_valid/dct_buffer/dct_count per-channel trace inputs;
// test_ending/test_has_ended drain control; rd_valid/rd_ready/rd_data/rd_cnt/rd_ch read port;
// ovf_count saturating drop counter; fifo_level occupancy; drain_busy/done state flags.
// Macro OCI_TRACE_TIMESTAMP_EN adds a 32-bit cycle counter and the rd_ts output.
module nios_oci_trace_monitor #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         dct_valid,
  input  logic [NUM_CH*DATA_W-1:0]  dct_buffer,
  input  logic [NUM_CH*CNT_W-1:0]   dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [CNT_W-1:0]          rd_cnt,
  output logic [2:0]                rd_ch,
  output logic [OVF_W-1:0]          ovf_count,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      drain_busy,
`ifdef OCI_TRACE_TIMESTAMP_EN
  output logic                      done,
  output logic [31:0]               rd_ts
`else
  output logic                      done
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [OVF_W-1:0] OVF_MAX = '1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [NUM_CH-1:0] hold_full, capture, grant;
  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic [CNT_W-1:0]  hold_cnt  [NUM_CH];
  logic [2:0] rr_ptr, cand, grant_idx;
  logic grant_vld, push, pop, full;
  logic [3:0] n_drop;
  logic [OVF_W+3:0] ovf_sum;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [CNT_W-1:0]  mem_cnt  [DEPTH];
  logic [2:0]        mem_ch   [DEPTH];

  assign full = level == (AW+1)'(DEPTH);
  assign rd_valid = level != '0 && !done;
  assign pop = rd_valid && rd_ready;
  // a full FIFO still accepts a word in the cycle its head is popped
  assign push = grant_vld && (!full || pop);
  assign fifo_level = level;
  assign rd_data = rd_valid ? mem_data[rd_ptr] : '0;
  assign rd_cnt = rd_valid ? mem_cnt[rd_ptr] : '0;
  assign rd_ch = rd_valid ? mem_ch[rd_ptr] : '0;
  assign state_nxt = (state == RUN && test_ending) ? DRAIN :
                     (state == DRAIN && test_has_ended && hold_full == '0 && level == '0) ? DONE : state;

  // round-robin: first occupied holding register scanning upward from rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = 3'((int'(rr_ptr) + k) % NUM_CH);
      if (!grant_vld && hold_full[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // a register being granted this cycle can take a new word, so that is not a drop
  always_comb begin
    grant = '0;
    capture = '0;
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = push && grant_idx == 3'(i);
      capture[i] = state == RUN && dct_valid[i] && (!hold_full[i] || grant[i]);
      n_drop = n_drop + 4'(state == RUN && dct_valid[i] && hold_full[i] && !grant[i]);
    end
    ovf_sum = (OVF_W+4)'(ovf_count) + (OVF_W+4)'(n_drop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      drain_busy <= 1'b0;
      done <= 1'b0;
      rr_ptr <= '0;
      ovf_count <= '0;
      hold_full <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_data[i] <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      drain_busy <= state_nxt == DRAIN;
      done <= state_nxt == DONE;
      if (push) rr_ptr <= (grant_idx == 3'(NUM_CH-1)) ? '0 : grant_idx + 3'd1;
      ovf_count <= (ovf_sum > (OVF_W+4)'(OVF_MAX)) ? OVF_MAX : ovf_sum[OVF_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          hold_full[i] <= 1'b1;
          hold_data[i] <= dct_buffer[i*DATA_W +: DATA_W];
          hold_cnt[i] <= dct_count[i*CNT_W +: CNT_W];
        end else if (grant[i]) begin
          hold_full[i] <= 1'b0;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= hold_data[grant_idx];
      mem_cnt[wr_ptr] <= hold_cnt[grant_idx];
      mem_ch[wr_ptr] <= grant_idx;
    end
  end

`ifdef OCI_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] hold_ts [NUM_CH];
  logic [31:0] mem_ts [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      for (int i = 0; i < NUM_CH; i++) if (capture[i]) hold_ts[i] <= ts_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr] <= hold_ts[grant_idx];
  end

  assign rd_ts = rd_valid ? mem_ts[rd_ptr] : '0;
`endif
endmodule

// File: doc/nios_oci_trace_monitor.md
Name: nios_oci_trace_monitor

Overview:
- Simulation/debug trace monitor for the multi-core Nios II OCI debug path.
- Each CPU channel presents a data/control trace (DCT) word and its count.
- Accepted words are arbitrated round-robin into one shared FIFO and read out over a valid/ready port.
- A drain state machine tracks test_ending / test_has_ended so a bench or JTAG bridge can collect every trace word before shutdown.

Parameters:
- NUM_CH, 5, number of CPU trace channels (1..8).
- DATA_W, 30, DCT word width per channel.
- CNT_W, 4, DCT count width per channel.
- DEPTH, 16, shared FIFO depth in entries; power of 2, at least 2.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dct_valid  in  NUM_CH  per-channel one-cycle strobe: new DCT word present
- dct_buffer  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- dct_count  in  NUM_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W]
- test_ending  in  1  level; stop accepting new trace words
- test_has_ended  in  1  level; bench finished, monitor may report done
- rd_ready  in  1  consumer ready
- rd_valid  out  1  FIFO head valid
- rd_data  out  DATA_W  head DCT word
- rd_cnt  out  CNT_W  head DCT count
- rd_ch  out  3  source channel index of the head entry
- ovf_count  out  OVF_W  dropped-word count, saturating
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy
- drain_busy  out  1  state is DRAIN
- done  out  1  state is DONE

Behaviour:
- Reset (asynchronous, reset_n low) clears all holding registers, FIFO pointers, the arbiter pointer and ovf_count, and sets state to RUN.
- Output values in reset: rd_valid=0, rd_data=0, rd_cnt=0, rd_ch=0, ovf_count=0, fifo_level=0, drain_busy=0, done=0.
- Asserting reset mid-operation discards all contents with no drain.

Per-channel holding register (1 entry):
- Captures {dct_count, dct_buffer} in state RUN when dct_valid[i]=1 and the register is empty, or is being emptied in the same cycle.
- A dct_valid[i] strobe while the register is full and not being emptied is a drop: the word is discarded and ovf_count increments by 1 (saturates at all-ones).
- Several channels dropping in the same cycle add the number of drops, still saturating.
- In DRAIN and DONE, dct_valid is ignored and does not count as a drop.

Arbiter:
- Each cycle the FIFO is not full, or is full and being popped, grant the lowest full holding register at or after rr_ptr (wrapping).
- On a grant, write the FIFO and set rr_ptr = granted index + 1, modulo NUM_CH.
- At most one write per cycle.

FIFO:
- Synchronous write, first-word-fall-through read.
- A word written in cycle N appears on rd_* in cycle N+1 if the FIFO was empty.
- rd_valid = (level != 0).
- Pop happens when rd_valid & rd_ready.
- rd_* holds stable while rd_valid=1 and rd_ready=0.
- Simultaneous push and pop when full is allowed; level is unchanged.
- Pointers wrap modulo DEPTH; level saturates at DEPTH with no overwrite.
- rd_ready while empty has no effect.

State machine:
- RUN -> DRAIN on test_ending=1.
- DRAIN -> DONE when test_has_ended=1, all holding registers are empty and the FIFO is empty.
- DONE is terminal until reset.
- test_has_ended in RUN without test_ending: stay in RUN.
- In DONE, rd_valid=0.
- drain_busy and done are registered, asserted the cycle after the transition.

Optional Feature:
- Macro: OCI_TRACE_TIMESTAMP_EN
- Defined:
  - Adds a 32-bit free-running cycle counter, cleared by reset and wrapping at 2^32.
  - Each holding register captures the counter value with the word.
  - Adds output rd_ts [31:0] carrying the head entry's timestamp.
  - Each FIFO entry widens by 32 bits.
- Undefined: no counter and no rd_ts port; behaviour is otherwise identical.

Test Plan:
- NUM_CH=5, DEPTH=16, rd_ready=1:
  - Stimulus: pulse dct_valid=5'b00001 with dct_buffer[29:0]=30'h1234567, count 4'h3.
  - Response: rd_valid=1 two cycles after the strobe with rd_data=30'h1234567, rd_cnt=3, rd_ch=0; ovf_count=0.
- rd_ready=1:
  - Stimulus: all 5 channels strobe in one cycle.
  - Response: 5 reads in order ch0..ch4 on consecutive cycles. A second all-channel burst then reads ch0..ch4 again; rr_ptr wraps.
- rd_ready=0:
  - Stimulus: channel 2 strobes 20 times, one per cycle.
  - Response: FIFO reaches level 16, holding register full; the remaining 3 words drop and ovf_count=3.
  - With OVF_W=2 and the same stimulus: ovf_count saturates at 3.
- Drain sequence:
  - Stimulus: fill 6 entries, assert test_ending, strobe channel 1, assert test_has_ended, then rd_ready=1.
  - Response: drain_busy=1; the channel-1 strobe is ignored; exactly 6 reads occur; done=1 the cycle after the FIFO empties and stays high; ovf_count is unchanged.
- Reset mid-operation:
  - Stimulus: pull reset_n low asynchronously mid-burst with the FIFO at level 9.
  - Response: rd_valid=0, fifo_level=0 and ovf_count=0 immediately, with no clock edge required; normal capture after release.
- OCI_TRACE_TIMESTAMP_EN defined:
  - Stimulus: channel 0 strobes at counter values 100 and 105.
  - Response: rd_ts reads 100 then 105.
